serial_addsub_ctrl: RTL and testbench



---
 rtl/serial_addsub_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor: one full-adder slice iterated LSB-first over WIDTH cycles,
// sequenced by a start/done handshake, with held Result, Cout and signed Overflow.
module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Overflow
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_load;
    logic             w_step;
    logic             w_last;

    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_work;
    logic             r_carry;
    logic [CW-1:0]    r_count;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_work_nxt;

    // Single full-adder slice on the current LSBs
    assign w_s        = r_op_a[0] ^ r_op_b[0] ^ r_carry;
    assign w_c        = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) | (r_op_b[0] & r_carry);
    assign w_work_nxt = WIDTH'({w_s, r_work} >> 1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            busy    <= (w_state_nxt == S_SHIFT);
            done    <= (w_state_nxt == S_DONE);
        end
    end

    // Next-state and datapath control
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_step = 1'b1;
                if (r_count == CW'(WIDTH - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand shift registers, carry, bit counter and held results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_work   <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            Result   <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
        end else if (w_load) begin
            r_op_a  <= A;
            r_op_b  <= sub ? ~B : B;
            r_carry <= sub;
            r_count <= '0;
        end else if (w_step) begin
            r_op_a  <= r_op_a >> 1;
            r_op_b  <= r_op_b >> 1;
            r_carry <= w_c;
            r_work  <= w_work_nxt;
            r_count <= r_count + CW'(1);
            if (w_last) begin
                Result   <= w_work_nxt;
                Cout     <= w_c;
                // r_carry still holds the carry into the MSB on this edge
                Overflow <= r_carry ^ w_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Randomized scoreboard bench for serial_addsub_ctrl (WIDTH=8) against an arithmetic model.
module tb_serial_addsub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] A;
    logic [7:0] B;
    logic       busy;
    logic       done;
    logic [7:0] Result;
    logic       Cout;
    logic       Overflow;

    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    logic [9:0] exp_q[$];
    logic [7:0] last_res = 8'h00;

    serial_addsub_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B),
        .busy(busy), .done(done), .Result(Result), .Cout(Cout), .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference: {Cout, Overflow, Result} from plain unsigned/signed arithmetic
    function automatic logic [9:0] model(input logic s, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        logic [7:0] r;
        logic       c;
        logic       v;
        if (!s) begin
            t = {1'b0, a} + {1'b0, b};
            r = t[7:0];
            c = t[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
        end else begin
            r = a - b;
            c = (a >= b);
            v = (a[7] != b[7]) && (r[7] != a[7]);
        end
        return {c, v, r};
    endfunction

    // Monitor: every done pulse consumes one scoreboard entry
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("result",   32'(Result),   32'(e[7:0]));
                check("cout",     32'(Cout),     32'(e[9]));
                check("overflow", 32'(Overflow), 32'(e[8]));
                check("busy_with_done", 32'(busy), 32'(0));
            end
        end
    end

    // One operation; poke >= 0 pulses start at that SHIFT cycle (must be ignored)
    task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b, input int poke);
        logic [9:0] e;
        int n;
        int nb;
        e = model(s, a, b);
        start = 1'b1; sub = s; A = a; B = b;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; A = 8'($urandom); B = 8'($urandom); sub = 1'($urandom);
        n = 0; nb = 0;
        while (!done && n < 20) begin
            if (busy) nb++;
            check("held_result", 32'(Result), 32'(last_res));
            if (n == poke) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check("latency", 32'(n), 32'(8));
        check("busy_cycles", 32'(nb), 32'(8));
        last_res = e[7:0];
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        check("done_falls", 32'(done), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = 8'h00; B = 8'h00;
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_result", 32'(Result), 32'(0));
        check("rst_cout", 32'(Cout), 32'(0));
        check("rst_ovf", 32'(Overflow), 32'(0));
        #20;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors from the plan
        run_op(1'b0, 8'h35, 8'h4A, -1); idle_cycle();
        run_op(1'b0, 8'hFF, 8'h01, -1); idle_cycle();
        run_op(1'b0, 8'h7F, 8'h01, -1); idle_cycle();
        run_op(1'b1, 8'h10, 8'h20, -1); idle_cycle();
        run_op(1'b1, 8'h80, 8'h01, -1); idle_cycle();

        // start held high: one op every 9 edges, operands scrambled during SHIFT
        start = 1'b1; sub = 1'b0; A = 8'h01; B = 8'h01;
        for (int op = 0; op < 3; op++) begin
            exp_q.push_back(model(1'b0, 8'h01, 8'h01));
            @(posedge clk); #1;
            for (int j = 0; j < 8; j++) begin
                check("cont_busy", 32'(busy), 32'(1));
                A = 8'($urandom); B = 8'($urandom); sub = 1'($urandom);
                @(posedge clk); #1;
            end
            check("cont_done", 32'(done), 32'(1));
            A = 8'h01; B = 8'h01; sub = 1'b0;
        end
        start = 1'b0;
        last_res = 8'h02;
        idle_cycle();

        // start pulse during SHIFT is not queued
        run_op(1'b0, 8'h03, 8'h09, 2); idle_cycle();
        repeat (3) begin
            @(posedge clk); #1;
            check("no_queue_busy", 32'(busy), 32'(0));
        end

        // Reset mid-SHIFT at count=4
        start = 1'b1; sub = 1'b0; A = 8'hAA; B = 8'h55;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_result", 32'(Result), 32'(0));
        check("abort_cout", 32'(Cout), 32'(0));
        check("abort_ovf", 32'(Overflow), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_res = 8'h00;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done), 32'(0));
        run_op(1'b0, 8'h03, 8'h04, -1);

        // Back-to-back from DONE, then randomized ops (some back-to-back)
        run_op(1'b1, 8'h05, 8'h05, -1); idle_cycle();
        for (int i = 0; i < 30; i++) begin
            run_op(1'($urandom), 8'($urandom), 8'($urandom), -1);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();
        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
